// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life cell family.
package life_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_STEP = 2'd2
    } mode_t;

    localparam int ST_DEAD  = 0;
    localparam int ST_ALIVE = 1;

    localparam logic [8:0] DEFAULT_BIRTH   = 9'b000001000;
    localparam logic [8:0] DEFAULT_SURVIVE = 9'b000001100;
    localparam logic [8:0] HIGHLIFE_BIRTH  = 9'b001001000;

endpackage

// File: rtl/neighbor_popcount.sv
// Counts live neighbours (0..8) from eight alive flags.
module neighbor_popcount (
    input  logic [7:0] flags,
    output logic [3:0] count
);

    logic [3:0] partial [0:8];

    assign partial[0] = 4'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_acc
            assign partial[gi+1] = partial[gi] + {3'd0, flags[gi]};
        end
    endgenerate

    assign count = partial[8];

endmodule

// File: rtl/life_cell_gen.sv
// Programmable-rule Life cell with Generations decay, run/hold/step control,
// seed loading, saturating age and a toggle pulse.
module life_cell_gen
    import life_pkg::*;
#(
    parameter  int NUM_STATES = 2,
    parameter  int AGE_W      = 4,
    localparam int SW         = (NUM_STATES <= 2) ? 1 : $clog2(NUM_STATES)
) (
    input  logic             Clock,
    input  logic             reset,
    input  mode_t            mode,
    input  logic             tick,
    input  logic             step,
    input  logic [7:0]       neighbor_alive,
    input  logic [8:0]       birth_mask,
    input  logic [8:0]       survive_mask,
    input  logic             seed_we,
    input  logic             seed_val,
    output logic             alive,
    output logic [SW-1:0]    state,
    output logic [AGE_W-1:0] age,
    output logic             changed
);

    localparam logic [SW-1:0] S_DEAD  = SW'(ST_DEAD);
    localparam logic [SW-1:0] S_ALIVE = SW'(ST_ALIVE);
    localparam logic [SW-1:0] S_FIRST = (NUM_STATES > 2) ? SW'(2) : S_DEAD;
    localparam logic [SW-1:0] S_LAST  = SW'(NUM_STATES - 1);

    logic [SW-1:0]    state_reg, state_next;
    logic [AGE_W-1:0] age_reg, age_next;
    logic             changed_reg, changed_next;
    logic             step_q_reg;
    logic [3:0]       cnt;
    logic             adv;

    neighbor_popcount u_popcount (
        .flags (neighbor_alive),
        .count (cnt)
    );

    // Step fires only on a rising edge seen while already in STEP mode.
    assign adv = ((mode == MODE_RUN) && tick) ||
                 ((mode == MODE_STEP) && step && !step_q_reg);

    always_comb begin
        state_next = state_reg;
        age_next   = age_reg;
        if (seed_we) begin
            state_next = seed_val ? S_ALIVE : S_DEAD;
            age_next   = '0;
        end else if (adv) begin
            if (state_reg == S_DEAD) begin
                state_next = birth_mask[cnt] ? S_ALIVE : S_DEAD;
                age_next   = '0;
            end else if (state_reg == S_ALIVE) begin
                if (survive_mask[cnt]) begin
                    if (age_reg != {AGE_W{1'b1}})
                        age_next = age_reg + 1'b1;
                end else begin
                    state_next = S_FIRST;
                    age_next   = '0;
                end
            end else begin
                // Decaying states ignore neighbours and walk toward DEAD.
                state_next = (state_reg == S_LAST) ? S_DEAD : state_reg + 1'b1;
                age_next   = '0;
            end
        end
        changed_next = (state_next == S_ALIVE) != (state_reg == S_ALIVE);
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_reg   <= S_DEAD;
            age_reg     <= '0;
            changed_reg <= 1'b0;
            step_q_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            age_reg     <= age_next;
            changed_reg <= changed_next;
            step_q_reg  <= step;
        end
    end

    assign state   = state_reg;
    assign age     = age_reg;
    assign alive   = (state_reg == S_ALIVE);
    assign changed = changed_reg;

endmodule

// File: tb/tb_life_cell_gen.sv
// Directed bench: a 2-state and a 4-state cell share one set of stimulus.
module tb_life_cell_gen;
    import life_pkg::*;

    logic       Clock = 1'b0;
    logic       reset = 1'b0;
    mode_t      mode = MODE_HOLD;
    logic       tick = 1'b0;
    logic       step = 1'b0;
    logic [7:0] nb = 8'd0;
    logic [8:0] bmask = DEFAULT_BIRTH;
    logic [8:0] smask = DEFAULT_SURVIVE;
    logic       seed_we = 1'b0;
    logic       seed_val = 1'b0;

    logic       alive2, changed2, alive4, changed4;
    logic [0:0] state2;
    logic [1:0] state4;
    logic [3:0] age2, age4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    life_cell_gen #(.NUM_STATES(2), .AGE_W(4)) dut2 (
        .Clock(Clock), .reset(reset), .mode(mode), .tick(tick), .step(step),
        .neighbor_alive(nb), .birth_mask(bmask), .survive_mask(smask),
        .seed_we(seed_we), .seed_val(seed_val),
        .alive(alive2), .state(state2), .age(age2), .changed(changed2)
    );

    life_cell_gen #(.NUM_STATES(4), .AGE_W(4)) dut4 (
        .Clock(Clock), .reset(reset), .mode(mode), .tick(tick), .step(step),
        .neighbor_alive(nb), .birth_mask(bmask), .survive_mask(smask),
        .seed_we(seed_we), .seed_val(seed_val),
        .alive(alive4), .state(state4), .age(age4), .changed(changed4)
    );

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic seed(input logic v);
        seed_we = 1'b1; seed_val = v; tick = 1'b0;
        cyc();
        seed_we = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_cmp++;
        if ({state2, age2, changed2, alive2} !== 7'd0) begin
            n_err++; $display("FAIL reset2: state=%0d age=%0d chg=%0b, required 0/0/0", state2, age2, changed2);
        end
        n_cmp++;
        if ({state4, age4, changed4, alive4} !== 8'd0) begin
            n_err++; $display("FAIL reset4: state=%0d age=%0d chg=%0b, required 0/0/0", state4, age4, changed4);
        end
        $display("reset: state2=%0d state4=%0d", state2, state4);
    endtask

    task automatic test_birth_death();
        mode = MODE_RUN;
        nb = 8'b0000_0111; tick = 1'b1;
        cyc();
        tick = 1'b0;
        n_cmp++;
        if ({alive2, state2, age2, changed2} !== {1'b1, 1'b1, 4'd0, 1'b1}) begin
            n_err++; $display("FAIL birth: alive=%0b state=%0d age=%0d chg=%0b, required 1/1/0/1", alive2, state2, age2, changed2);
        end
        cyc();
        n_cmp++;
        if (changed2 !== 1'b0) begin
            n_err++; $display("FAIL birth_pulse_len: chg=%0b, required 0", changed2);
        end
        nb = 8'b0000_0001; tick = 1'b1;
        cyc();
        tick = 1'b0;
        n_cmp++;
        if ({alive2, changed2} !== 2'b01) begin
            n_err++; $display("FAIL death: alive=%0b chg=%0b, required 0/1", alive2, changed2);
        end
        cyc();
        n_cmp++;
        if (changed2 !== 1'b0) begin
            n_err++; $display("FAIL death_pulse_len: chg=%0b, required 0", changed2);
        end
        $display("birth_death: alive2=%0b", alive2);
    endtask

    task automatic test_age();
        logic [3:0] exp_age;
        mode = MODE_RUN;
        seed(1'b1);
        n_cmp++;
        if ({alive2, age2} !== {1'b1, 4'd0}) begin
            n_err++; $display("FAIL seed_alive: alive=%0b age=%0d, required 1/0", alive2, age2);
        end
        nb = 8'b0000_0011;
        for (int i = 1; i <= 20; i++) begin
            tick = 1'b1;
            cyc();
            exp_age = (i > 15) ? 4'd15 : 4'(i);
            n_cmp++;
            if ({alive2, age2} !== {1'b1, exp_age}) begin
                n_err++; $display("FAIL age_%0d: alive=%0b age=%0d, required 1/%0d", i, alive2, age2, exp_age);
            end
        end
        nb = 8'b0000_1111;
        cyc();
        tick = 1'b0;
        n_cmp++;
        if ({alive2, age2, changed2} !== {1'b0, 4'd0, 1'b1}) begin
            n_err++; $display("FAIL overcrowd: alive=%0b age=%0d chg=%0b, required 0/0/1", alive2, age2, changed2);
        end
        $display("age: final age2=%0d", age2);
    endtask

    task automatic test_decay();
        logic [1:0] exp_st [4];
        logic       exp_chg [4];
        exp_st  = '{2'd2, 2'd3, 2'd0, 2'd1};
        exp_chg = '{1'b1, 1'b0, 1'b0, 1'b1};
        mode = MODE_RUN;
        seed(1'b1);
        nb = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            cyc();
            nb = 8'b0000_0111;
            n_cmp++;
            if ({state4, alive4, changed4, age4} !== {exp_st[i], exp_st[i] == 2'd1, exp_chg[i], 4'd0}) begin
                n_err++; $display("FAIL decay_%0d: state=%0d alive=%0b chg=%0b age=%0d, required %0d/%0b/%0b/0",
                                  i, state4, alive4, changed4, age4, exp_st[i], exp_st[i] == 2'd1, exp_chg[i]);
            end
        end
        tick = 1'b0;
        $display("decay: state4=%0d", state4);
    endtask

    task automatic test_modes();
        int chg_seen;
        mode = MODE_RUN;
        seed(1'b0);
        mode = MODE_HOLD;
        nb = 8'b0000_0111; tick = 1'b1; step = 1'b0;
        chg_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) step = 1'b1;
            cyc();
            chg_seen += changed2;
        end
        n_cmp++;
        if (state2 !== 1'b0 || chg_seen != 0) begin
            n_err++; $display("FAIL hold: state=%0d changes=%0d, required 0/0", state2, chg_seen);
        end
        // step is already high: entering STEP must not see an edge.
        mode = MODE_STEP;
        cyc();
        n_cmp++;
        if (state2 !== 1'b0) begin
            n_err++; $display("FAIL step_stale_edge: state=%0d, required 0", state2);
        end
        step = 1'b0;
        cyc();
        step = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        n_cmp++;
        if ({alive2, age2} !== {1'b1, 4'd0}) begin
            n_err++; $display("FAIL step_once: alive=%0b age=%0d, required 1/0", alive2, age2);
        end
        step = 1'b0;
        cyc();
        step = 1'b1;
        cyc();
        n_cmp++;
        if ({alive2, age2} !== {1'b1, 4'd1}) begin
            n_err++; $display("FAIL step_twice: alive=%0b age=%0d, required 1/1", alive2, age2);
        end
        step = 1'b0; tick = 1'b0; mode = MODE_RUN;
        $display("modes: age2=%0d", age2);
    endtask

    task automatic test_simultaneous();
        mode = MODE_RUN;
        seed(1'b0);
        nb = 8'b0000_0111; tick = 1'b1; seed_we = 1'b1; seed_val = 1'b0;
        cyc();
        seed_we = 1'b0; tick = 1'b0;
        n_cmp++;
        if ({state2, changed2} !== 2'b00) begin
            n_err++; $display("FAIL seed_over_adv: state=%0d chg=%0b, required 0/0", state2, changed2);
        end
        seed(1'b1);
        nb = 8'b0000_0011; tick = 1'b1;
        for (int i = 0; i < 7; i++) cyc();
        n_cmp++;
        if (age2 !== 4'd7) begin
            n_err++; $display("FAIL pre_reset_age: age=%0d, required 7", age2);
        end
        reset = 1'b1; seed_we = 1'b1; seed_val = 1'b1;
        cyc();
        reset = 1'b0; seed_we = 1'b0; tick = 1'b0;
        n_cmp++;
        if ({state2, age2, changed2} !== 6'd0) begin
            n_err++; $display("FAIL mid_reset: state=%0d age=%0d chg=%0b, required 0/0/0", state2, age2, changed2);
        end
        $display("simultaneous: state2=%0d", state2);
    endtask

    task automatic test_highlife();
        mode = MODE_RUN;
        bmask = HIGHLIFE_BIRTH;
        seed(1'b0);
        nb = 8'b0011_1111; tick = 1'b1;
        cyc();
        tick = 1'b0;
        n_cmp++;
        if (alive2 !== 1'b1) begin
            n_err++; $display("FAIL highlife_b6: alive=%0b, required 1", alive2);
        end
        bmask = DEFAULT_BIRTH;
        seed(1'b0);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        n_cmp++;
        if (alive2 !== 1'b0) begin
            n_err++; $display("FAIL default_b6: alive=%0b, required 0", alive2);
        end
        $display("highlife: alive2=%0b", alive2);
    endtask

    initial begin
        test_reset();
        test_birth_death();
        test_age();
        test_decay();
        test_modes();
        test_simultaneous();
        test_highlife();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
